// File: rtl/cpu_nios_led_ctrl_if.sv
// Avalon-MM slave bus bundle for the LED controller: word address, select,
// active-low write strobe, write data and the combinational read data.
interface cpu_nios_led_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/cpu_nios_led_ctrl.sv
// LED output port with per-bit blink masking, driven from an Avalon-MM slave.
// Register map: 0 DATA, 1 BLINK_EN, 2 PERIOD, 4 OUTSET, 5 OUTCLEAR, 6 STATUS.
// A free-running prescaler toggles a blink phase every PERIOD clocks; bits
// enabled in BLINK_EN are forced low while the phase is 1.
module cpu_nios_led_ctrl #(
  parameter int unsigned       WIDTH       = 10,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
  parameter logic [31:0]       BLINK_DIV   = 32'd25000000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  cpu_nios_led_ctrl_if.slave    bus,
  output logic [WIDTH-1:0]      out_port
);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;
  localparam logic [2:0] ADDR_STATUS   = 3'd6;

  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_blinkEn;
  logic [31:0]      r_period;
  logic [31:0]      r_count;
  logic             r_phase;

  logic             w_write;
  logic             w_periodWrite;
  logic [WIDTH-1:0] w_writeBits;
  logic [31:0]      w_readdata;

  assign w_write       = bus.chipselect & ~bus.write_n;
  assign w_periodWrite = w_write && (bus.address == ADDR_PERIOD);
  assign w_writeBits   = bus.writedata[WIDTH-1:0];

  // Bus writes into DATA, BLINK_EN and PERIOD, including the OUTSET/OUTCLEAR
  // read-modify-write aliases of DATA; PERIOD 0 is stored as 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data    <= RESET_VALUE;
      r_blinkEn <= '0;
      r_period  <= BLINK_DIV;
    end else if (w_write) begin
      case (bus.address)
        ADDR_DATA:     r_data    <= w_writeBits;
        ADDR_BLINK_EN: r_blinkEn <= w_writeBits;
        ADDR_PERIOD:   r_period  <= (bus.writedata == 32'd0) ? 32'd1 : bus.writedata;
        ADDR_OUTSET:   r_data    <= r_data | w_writeBits;
        ADDR_OUTCLEAR: r_data    <= r_data & ~w_writeBits;
        default:       ;
      endcase
    end
  end

  // Prescaler and blink phase; a PERIOD write restarts the half-period and
  // overrides a terminal count landing on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      r_phase <= 1'b0;
    end else if (w_periodWrite) begin
      r_count <= '0;
      r_phase <= 1'b0;
    end else if (r_count == (r_period - 32'd1)) begin
      r_count <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_count <= r_count + 32'd1;
    end
  end

  // Zero-wait-state read mux, driven regardless of chipselect.
  always_comb begin
    w_readdata = '0;
    case (bus.address)
      ADDR_DATA:     w_readdata[WIDTH-1:0] = r_data;
      ADDR_BLINK_EN: w_readdata[WIDTH-1:0] = r_blinkEn;
      ADDR_PERIOD:   w_readdata            = r_period;
      ADDR_STATUS:   w_readdata[0]         = r_phase;
      default:       w_readdata            = '0;
    endcase
  end

  assign bus.readdata = w_readdata;

  // LED drive depends only on registers, so bus inputs never reach it combinationally.
  assign out_port = r_data & ~(r_blinkEn & {WIDTH{r_phase}});

endmodule

// File: tb/tb_cpu_nios_led_ctrl.sv
// Directed bench for cpu_nios_led_ctrl with WIDTH=10, RESET_VALUE=0x155,
// BLINK_DIV=4. Inputs change while clk is low, outputs sampled after negedge.
module tb_cpu_nios_led_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [9:0] out_port;
  int         testsRun = 0;
  int         testsFailed = 0;

  cpu_nios_led_ctrl_if bus ();

  cpu_nios_led_ctrl #(
    .WIDTH       (10),
    .RESET_VALUE (10'h155),
    .BLINK_DIV   (32'd4)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .out_port (out_port)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // One bus write: strobes held across one rising edge, released at the next negedge.
  task automatic applyStimulus(input logic [2:0] addr, input logic [31:0] data);
    if (clk) @(negedge clk);
    bus.address    = addr;
    bus.writedata  = data;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  // Single comparison with failure accounting.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Combinational readback of one address.
  task automatic checkRead(input string tag, input logic [2:0] addr, input logic [31:0] expected);
    bus.address = addr;
    #1;
    checkOutput(tag, bus.readdata, expected);
  endtask

  // Directed sequence.
  initial begin
    bus.address    = 3'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'd0;

    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Reset state
    #1;
    checkOutput("reset_out_port", {22'd0, out_port}, 32'h155);
    checkRead("reset_data", 3'd0, 32'h155);
    checkRead("reset_blink_en", 3'd1, 32'h0);
    checkRead("reset_period", 3'd2, 32'h4);
    checkRead("reset_status", 3'd6, 32'h0);

    // DATA write with upper bits ignored, then OUTSET / OUTCLEAR
    applyStimulus(3'd0, 32'hFFFFF0F0);
    checkRead("data_write", 3'd0, 32'h0F0);
    checkOutput("data_out_port", {22'd0, out_port}, 32'h0F0);
    applyStimulus(3'd4, 32'h0000000F);
    checkRead("outset", 3'd0, 32'h0FF);
    checkOutput("outset_out_port", {22'd0, out_port}, 32'h0FF);
    applyStimulus(3'd5, 32'h000000F0);
    checkRead("outclear", 3'd0, 32'h00F);
    checkOutput("outclear_out_port", {22'd0, out_port}, 32'h00F);

    // Blink with PERIOD=3: 3 clocks 0x3FF, 3 clocks 0x3FC
    applyStimulus(3'd0, 32'h000003FF);
    applyStimulus(3'd1, 32'hFFFFFC03);
    checkRead("blink_en_write", 3'd1, 32'h003);
    applyStimulus(3'd2, 32'd3);
    checkRead("period_3", 3'd2, 32'd3);
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      bus.address = 3'd6;
      #1;
      checkOutput($sformatf("blink_out_%0d", i), {22'd0, out_port},
                  (((i / 3) % 2) == 1) ? 32'h3FC : 32'h3FF);
      checkOutput($sformatf("blink_status_%0d", i), bus.readdata, 32'((i / 3) % 2));
    end

    // PERIOD=0 stored as 1, phase toggles every clock
    @(negedge clk);
    applyStimulus(3'd2, 32'd0);
    checkRead("period_zero", 3'd2, 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      bus.address = 3'd6;
      #1;
      checkOutput($sformatf("p1_status_%0d", i), bus.readdata, 32'(i % 2));
    end

    // PERIOD=5 written at terminal count during phase 1
    applyStimulus(3'd2, 32'd5);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      bus.address = 3'd6;
      #1;
      checkOutput($sformatf("p5_status_%0d", i), bus.readdata, (i == 5) ? 32'd1 : 32'd0);
    end

    // PERIOD write at terminal count during phase 0 keeps phase 0
    applyStimulus(3'd2, 32'd1);
    applyStimulus(3'd2, 32'd2);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      bus.address = 3'd6;
      #1;
      checkOutput($sformatf("prio_status_%0d", i), bus.readdata, (i == 2) ? 32'd1 : 32'd0);
    end

    // Writes to STATUS and reserved addresses have no effect and read 0
    @(negedge clk);
    applyStimulus(3'd6, 32'h00000001);
    applyStimulus(3'd3, 32'hFFFFFFFF);
    applyStimulus(3'd7, 32'hFFFFFFFF);
    checkRead("ro_data", 3'd0, 32'h3FF);
    checkRead("ro_blink_en", 3'd1, 32'h003);
    checkRead("ro_period", 3'd2, 32'd2);
    checkRead("rd_addr3", 3'd3, 32'h0);
    checkRead("rd_addr4", 3'd4, 32'h0);
    checkRead("rd_addr5", 3'd5, 32'h0);
    checkRead("rd_addr7", 3'd7, 32'h0);

    // Asynchronous reset mid-blink, then write in the release cycle
    @(negedge clk);
    applyStimulus(3'd2, 32'd3);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("pre_reset_out", {22'd0, out_port}, 32'h3FC);
    reset_n = 1'b0;
    bus.address = 3'd6;
    #1;
    checkOutput("async_reset_out", {22'd0, out_port}, 32'h155);
    checkOutput("async_reset_status", bus.readdata, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(3'd0, 32'h000002AA);
    checkRead("release_write", 3'd0, 32'h2AA);
    checkOutput("release_out", {22'd0, out_port}, 32'h2AA);
    for (int i = 1; i < 5; i++) begin
      if (i > 1) @(negedge clk);
      bus.address = 3'd6;
      #1;
      checkOutput($sformatf("release_status_%0d", i), bus.readdata, (i == 4) ? 32'd1 : 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/cpu_nios_led_ctrl.md
CPU_NIOS_LED_CTRL -- requirements
Module: cpu_nios_led_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 10, meaning output port width (legal 1..32).
REQ-002 The block SHALL have parameter RESET_VALUE, default 0, meaning DATA register value after reset (WIDTH bits).
REQ-003 The block SHALL have parameter BLINK_DIV, default 25000000, meaning PERIOD register reset value (clocks per blink half-period, 1..2^32-1).
REQ-004 Port clk  input  1  single clock; all state on its rising edge.
REQ-005 Port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Port address  input  3  Avalon-MM word address.
REQ-007 Port chipselect  input  1  slave select.
REQ-008 Port write_n  input  1  active-low write strobe.
REQ-009 Port writedata  input  32  write data.
REQ-010 Port readdata  output  32  read data, combinational, zero wait states.
REQ-011 Port out_port  output  WIDTH  LED drive.

Function
REQ-012 A write SHALL occur when chipselect=1 and write_n=0; the register update SHALL be visible on readdata and out_port the cycle after the write edge.
REQ-013 Address map SHALL be: 0 DATA (r/w), 1 BLINK_EN (r/w), 2 PERIOD (r/w, 32 bits), 3 reserved, 4 OUTSET (wo), 5 OUTCLEAR (wo), 6 STATUS (ro), 7 reserved.
REQ-014 Writes to DATA/BLINK_EN SHALL load writedata[WIDTH-1:0]; upper writedata bits SHALL be ignored.
REQ-015 Write to OUTSET SHALL perform DATA <= DATA | writedata[WIDTH-1:0]; OUTCLEAR SHALL perform DATA <= DATA & ~writedata[WIDTH-1:0].
REQ-016 Write to PERIOD SHALL load writedata; value 0 SHALL be stored as 1.
REQ-017 Writes to addresses 3, 6, 7 SHALL have no effect.
REQ-018 readdata SHALL return the addressed register zero-extended to 32 bits; addresses 3, 4, 5, 7 SHALL read 0; STATUS SHALL read {31'b0, phase}.
REQ-019 readdata SHALL be driven regardless of chipselect (bus fabric qualifies it).
REQ-020 A 32-bit prescaler counter SHALL increment every clock; when counter == PERIOD-1 it SHALL return to 0 and phase SHALL toggle on the same edge.
REQ-021 Half-period SHALL therefore be exactly PERIOD clocks; PERIOD=1 SHALL toggle phase every clock.
REQ-022 A write to PERIOD SHALL clear counter and phase to 0 on the same edge, taking priority over a coincident terminal count.
REQ-023 A write to BLINK_EN SHALL NOT disturb counter or phase.
REQ-024 out_port SHALL equal DATA & ~(BLINK_EN & {WIDTH{phase}}), registered-equivalent (no combinational path from bus inputs to out_port).
REQ-025 Bits with BLINK_EN=0 SHALL follow DATA steadily; bits with BLINK_EN=1 SHALL show DATA during phase 0 and 0 during phase 1.

Reset
REQ-026 On reset_n=0, asynchronously: DATA=RESET_VALUE, BLINK_EN=0, PERIOD=BLINK_DIV, counter=0, phase=0, so out_port=RESET_VALUE.
REQ-027 Reset asserted mid-blink SHALL abort the half-period; after release counting SHALL restart from 0 with phase 0.
REQ-028 Writes in the cycle reset_n deasserts SHALL take effect normally on the next rising edge.

Verification (WIDTH=10, BLINK_DIV=4 unless stated)
REQ-029 Reset release with RESET_VALUE=0x155 -> out_port=0x155, reads: addr0=0x155, addr1=0, addr2=4, addr6=0.
REQ-030 Write addr0=0xFFFFF0F0 -> readdata addr0=0x0F0, out_port=0x0F0 next cycle; then OUTSET 0x00F -> 0x0FF; OUTCLEAR 0x0F0 -> 0x00F.
REQ-031 DATA=0x3FF, BLINK_EN=0x003, PERIOD=3 -> out_port alternates 0x3FF (3 clocks) / 0x3FC (3 clocks), STATUS bit0 tracks phase.
REQ-032 Write PERIOD=0 -> reads back 1; phase toggles every clock; write PERIOD=5 during phase 1 at counter terminal -> phase=0, counter=0, next toggle exactly 5 clocks later.
REQ-033 Write addr6=0x1, addr3/addr7 arbitrary -> no register changes, those addresses read 0.
REQ-034 Assert reset_n mid-half-period with blinking active -> out_port=RESET_VALUE immediately without waiting for clk; after release first toggle after exactly BLINK_DIV clocks.
